cla_add16_sequencer: RTL and testbench
======================================

CLA_ADD16_SEQUENCER -- requirements
Module: cla_add16_sequencer

Interface
REQ-001 Parameter: ADD_LAT, default 2, cycles from driving a nibble on add_a/add_b/add_cin until add_s/add_cout are valid (2 = input-flop + output-flop adder stage).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  operand request valid.
REQ-005 in_ready  output  1  sequencer can accept a request.
REQ-006 op_a  input  16  operand A.
REQ-007 op_b  input  16  operand B.
REQ-008 cin  input  1  carry-in for bit 0.
REQ-009 add_a  output  4  nibble of A to the 4-bit CLA adder stage.
REQ-010 add_b  output  4  nibble of B to the adder stage.
REQ-011 add_cin  output  1  carry-in to the adder stage.
REQ-012 add_s  input  4  registered sum from the adder stage.
REQ-013 add_cout  input  1  registered carry-out from the adder stage.
REQ-014 out_valid  output  1  result valid.
REQ-015 out_ready  input  1  consumer accepts result.
REQ-016 sum  output  16  op_a + op_b + cin, modulo 2^16.
REQ-017 cout  output  1  carry out of bit 15.

Function
REQ-018 States: IDLE, ISSUE, WAIT, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE (both Moore-decoded from state).
REQ-019 IDLE: in_valid & in_ready at an edge latches op_a, op_b, cin into internal registers, clears nibble index to 0 and sum register to 0, goes to ISSUE.
REQ-020 ISSUE (one cycle): add_a = A_reg[4i+3:4i], add_b = B_reg[4i+3:4i], add_cin = carry register (latched cin for i=0, captured add_cout of nibble i-1 otherwise); go to WAIT with wait counter = ADD_LAT.
REQ-021 Outside ISSUE, add_a, add_b and add_cin SHALL be driven 0.
REQ-022 WAIT: counter decrements each cycle; at the edge ending the cycle ADD_LAT cycles after the ISSUE cycle, capture add_s into sum[4i+3:4i] and add_cout into carry register.
REQ-023 After capture: if i < 3, increment i and go to ISSUE; if i = 3, go to DONE with cout = captured add_cout.
REQ-024 Nibble index is 2 bits; no wrap beyond 3 occurs; only one nibble is in flight at a time.
REQ-025 Latency: out_valid first high 4*(ADD_LAT+1)+1 cycles after the acceptance edge (13 for ADD_LAT=2).
REQ-026 DONE: sum, cout, out_valid held stable while out_ready = 0; in_valid ignored; op_a/op_b changes have no effect.
REQ-027 DONE with out_ready = 1 at an edge: go to IDLE; in_ready = 1 in the following cycle; no accept in the same cycle as result handoff.
REQ-028 sum and cout retain their values after handoff until the next acceptance clears sum.
REQ-029 add_s/add_cout are sampled only at capture edges; values outside capture edges (including stale adder pipeline contents after reset) SHALL NOT affect state.

Reset
REQ-030 rst_n = 0 SHALL immediately force state IDLE, index 0, wait counter 0, carry 0, operand registers 0, sum = 0, cout = 0, out_valid = 0, in_ready = 1, add_a/add_b/add_cin = 0.
REQ-031 Reset mid-operation aborts the add with no result produced; the first request after rst_n deasserts SHALL complete correctly with normal latency.

Verification
REQ-032 0x0000 + 0x0000, cin 0 -> sum 0x0000, cout 0, out_valid exactly 13 cycles after acceptance.
REQ-033 0xFFFF + 0x0001, cin 0 -> sum 0x0000, cout 1 (carry ripples through all four nibbles).
REQ-034 0x1234 + 0x4321, cin 1 -> sum 0x5556, cout 0; 0x7FFF + 0x0000, cin 1 -> sum 0x8000, cout 0; 0x8000 + 0x8000, cin 0 -> sum 0x0000, cout 1.
REQ-035 Hold out_ready = 0 for 5 cycles in DONE while toggling in_valid/op_a -> sum, cout, out_valid unchanged, in_ready 0; raise out_ready -> IDLE next cycle, in_ready 1.
REQ-036 Assert rst_n = 0 during WAIT of nibble 1 -> all outputs reset values immediately; release, send 0xABCD + 0x1111, cin 0 -> sum 0xBCDE, cout 0 after 13 cycles.
REQ-037 Back-to-back: 100 random requests with random out_ready stalls -> every result matches op_a + op_b + cin against a reference model; nibble drive observed only in ISSUE cycles.

Source files
------------

// File: rtl/cla_add16_sequencer.sv
// Sequences a 16-bit add through an external 4-bit adder stage, one nibble at a time,
// rippling the carry through a register between nibbles.
module cla_add16_sequencer #(
  parameter int unsigned ADD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  input  logic        cin,
  output logic [3:0]  add_a,
  output logic [3:0]  add_b,
  output logic        add_cin,
  input  logic [3:0]  add_s,
  input  logic        add_cout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] sum,
  output logic        cout
);

  localparam int unsigned CNT_W = (ADD_LAT < 2) ? 1 : $clog2(ADD_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t           state_q, state_n;
  logic [1:0]       idx_q, idx_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             carry_q, carry_n;
  logic [15:0]      a_q, a_n;
  logic [15:0]      b_q, b_n;
  logic [15:0]      sum_n;
  logic             cout_n;
  logic [3:0]       add_a_n, add_b_n;
  logic             add_cin_n;

  // Next-state and next-output decode; outputs are registered from the next state.
  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    cnt_n   = cnt_q;
    carry_n = carry_q;
    a_n     = a_q;
    b_n     = b_q;
    sum_n   = sum;
    cout_n  = cout;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_n     = op_a;
          b_n     = op_b;
          carry_n = cin;
          idx_n   = 2'd0;
          sum_n   = 16'd0;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        cnt_n   = CNT_W'(ADD_LAT);
        state_n = WAIT;
      end
      WAIT: begin
        cnt_n = cnt_q - CNT_W'(1);
        // Adder result is only trusted on the last wait cycle of this nibble.
        if (cnt_q == CNT_W'(1)) begin
          sum_n[{idx_q, 2'b00} +: 4] = add_s;
          carry_n = add_cout;
          if (idx_q == 2'd3) begin
            cout_n  = add_cout;
            state_n = DONE;
          end else begin
            idx_n   = idx_q + 2'd1;
            state_n = ISSUE;
          end
        end
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    add_a_n   = 4'd0;
    add_b_n   = 4'd0;
    add_cin_n = 1'b0;
    if (state_n == ISSUE) begin
      add_a_n   = 4'(a_n >> {idx_n, 2'b00});
      add_b_n   = 4'(b_n >> {idx_n, 2'b00});
      add_cin_n = carry_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= 2'd0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      a_q       <= 16'd0;
      b_q       <= 16'd0;
      sum       <= 16'd0;
      cout      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      add_a     <= 4'd0;
      add_b     <= 4'd0;
      add_cin   <= 1'b0;
    end else begin
      state_q   <= state_n;
      idx_q     <= idx_n;
      cnt_q     <= cnt_n;
      carry_q   <= carry_n;
      a_q       <= a_n;
      b_q       <= b_n;
      sum       <= sum_n;
      cout      <= cout_n;
      in_ready  <= (state_n == IDLE);
      out_valid <= (state_n == DONE);
      add_a     <= add_a_n;
      add_b     <= add_b_n;
      add_cin   <= add_cin_n;
    end
  end

endmodule

// File: tb/tb_cla_add16_sequencer.sv
// Scoreboard bench: random and directed adds, an external two-stage adder model,
// and a negedge monitor checking results, latency, hold, retention and nibble drive.
module tb_cla_add16_sequencer;

  localparam int unsigned ADD_LAT = 2;
  localparam int P = ADD_LAT + 1;
  localparam int LAT = 4 * P + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] op_a = 16'd0;
  logic [15:0] op_b = 16'd0;
  logic        cin = 1'b0;
  logic [3:0]  add_a, add_b;
  logic        add_cin;
  logic [3:0]  add_s;
  logic        add_cout;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] sum;
  logic        cout;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic rand_ready = 1'b0;

  typedef struct {
    logic [15:0] s;
    logic        c;
    int          acc;
  } exp_t;
  exp_t q[$];

  logic        inflight = 1'b0;
  logic [15:0] cur_a, cur_b;
  logic        cur_c;
  int          cur_acc;
  logic        prev_valid = 1'b0, prev_hs = 1'b0, prev_c = 1'b0, last_c = 1'b0;
  logic [15:0] prev_s = 16'd0, last_s = 16'd0;

  cla_add16_sequencer #(.ADD_LAT(ADD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .cin(cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  // External adder stage: input flop then output flop, never reset.
  logic [3:0] s1_a = 4'hA, s1_b = 4'h7;
  logic       s1_c = 1'b1;
  initial begin add_s = 4'h5; add_cout = 1'b1; end
  always @(posedge clk) begin
    s1_a <= add_a;
    s1_b <= add_b;
    s1_c <= add_cin;
    {add_cout, add_s} <= 5'(s1_a) + 5'(s1_b) + 5'(s1_c);
  end

  always @(posedge clk) cyc = cyc + 1;

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Carry into bit 4*i from a plain sum of the lower bits.
  function automatic logic exp_carry(input logic [15:0] a, input logic [15:0] b,
                                     input logic c, input int i);
    logic [15:0] m;
    logic [16:0] t;
    m = 16'((32'd1 << (4 * i)) - 32'd1);
    t = 17'(a & m) + 17'(b & m) + 17'(c);
    return t[4 * i];
  endfunction

  // Monitor: sample mid-cycle, handshakes take effect at the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      inflight   = 1'b0;
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
      last_s     = 16'd0;
      last_c     = 1'b0;
    end else begin
      int off, i;
      logic [3:0] ea, eb;
      logic ec;
      logic hs;
      logic [16:0] r;
      exp_t e;
      ea = 4'd0; eb = 4'd0; ec = 1'b0;
      if (inflight) begin
        off = cyc - cur_acc;
        if (off >= 1 && off <= 4 * P && ((off - 1) % P) == 0) begin
          i  = (off - 1) / P;
          ea = 4'(cur_a >> (4 * i));
          eb = 4'(cur_b >> (4 * i));
          ec = exp_carry(cur_a, cur_b, cur_c, i);
        end
      end
      chk("nibble_drive", {23'd0, add_a, add_b, add_cin}, {23'd0, ea, eb, ec});
      chk("ready_valid_excl", 32'(in_ready & out_valid), 32'd0);
      if (out_valid && !prev_valid) begin
        if (q.size() == 0) chk("unexpected_result", 32'd1, 32'd0);
        else chk("latency", 32'(cyc - q[0].acc), 32'(LAT));
        inflight = 1'b0;
      end
      if (out_valid && prev_valid && !prev_hs)
        chk("done_hold", {15'd0, cout, sum}, {15'd0, prev_c, prev_s});
      if (in_ready && !out_valid)
        chk("retain", {15'd0, cout, sum}, {15'd0, last_c, last_s});
      hs = out_valid && out_ready;
      if (hs && q.size() != 0) begin
        e = q.pop_front();
        chk("result_sum", 32'(sum), 32'(e.s));
        chk("result_cout", 32'(cout), 32'(e.c));
        last_s = e.s;
        last_c = e.c;
      end
      if (in_valid && in_ready) begin
        r = 17'(op_a) + 17'(op_b) + 17'(cin);
        e.s = r[15:0];
        e.c = r[16];
        e.acc = cyc;
        q.push_back(e);
        inflight = 1'b1;
        cur_a = op_a; cur_b = op_b; cur_c = cin; cur_acc = cyc;
      end
      prev_valid = out_valid;
      prev_s     = sum;
      prev_c     = cout;
      prev_hs    = hs;
    end
  end

  // Called just after a rising edge; returns just after the acceptance edge.
  task automatic do_req(input logic [15:0] a, input logic [15:0] b, input logic c);
    int n;
    op_a = a; op_b = b; cin = c; in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 500);
    if (!in_ready) chk("accept_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_a = 16'($urandom);
    op_b = 16'($urandom);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q.size() != 0 || inflight) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0 || inflight) chk("drain_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_sum"}, 32'(sum), 32'd0);
    chk({tag, "_cout"}, 32'(cout), 32'd0);
    chk({tag, "_adder_drive"}, {23'd0, add_a, add_b, add_cin}, 32'd0);
  endtask

  logic [15:0] dir_a[5] = '{16'h0000, 16'hFFFF, 16'h1234, 16'h7FFF, 16'h8000};
  logic [15:0] dir_b[5] = '{16'h0000, 16'h0001, 16'h4321, 16'h0000, 16'h8000};
  logic        dir_c[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [15:0] dir_s[5] = '{16'h0000, 16'h0000, 16'h5556, 16'h8000, 16'h0000};
  logic        dir_o[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    logic [15:0] hs_s;
    logic hs_c;
    int n;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 5; k++) begin
      do_req(dir_a[k], dir_b[k], dir_c[k]);
      wait_drain();
      chk("dir_sum", 32'(sum), 32'(dir_s[k]));
      chk("dir_cout", 32'(cout), 32'(dir_o[k]));
    end

    // Stall the consumer and wiggle inputs while the result is presented.
    out_ready = 1'b0;
    do_req(16'h2468, 16'h1357, 1'b1);
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 100);
    chk("stall_reached_done", 32'(out_valid), 32'd1);
    hs_s = sum; hs_c = cout;
    chk("stall_sum", 32'(hs_s), 32'h37C0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      in_valid = ~in_valid;
      op_a = 16'($urandom);
      @(negedge clk);
      chk("stall_sum_hold", 32'(sum), 32'(hs_s));
      chk("stall_cout_hold", 32'(cout), 32'(hs_c));
      chk("stall_valid_hold", 32'(out_valid), 32'd1);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("handoff_in_ready", 32'(in_ready), 32'd1);
    chk("handoff_out_valid", 32'(out_valid), 32'd0);

    // Abort during the wait of nibble 1, then a clean add.
    do_req(16'h1234, 16'h1111, 1'b0);
    repeat (P + 1) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    do_req(16'hABCD, 16'h1111, 1'b0);
    wait_drain();
    chk("post_reset_sum", 32'(sum), 32'hBCDE);
    chk("post_reset_cout", 32'(cout), 32'd0);

    rand_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      b = 16'($urandom);
      if ($urandom_range(0, 7) == 0) a = 16'hFFFF;
      if ($urandom_range(0, 7) == 0) b = 16'h0000;
      do_req(a, b, 1'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #0;
    end
    wait_drain();
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
